hamming_encode_pipe: RTL

- Pipelined, parametrised Hamming/SECDED encoder with a valid/ready stream interface on both sides.
- Packs DATA_WIDTH data bits into non-power-of-two code positions and computes parity bits at positions 2^i.
- Optionally fills position 0 with overall parity for SECDED.
- Carries a per-beat error-injection sideband for decoder verification. Sits between producer logic and storage/link paths ahead of the matching decoder.

---
 rtl/hamming_encode_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hamming_encode_pipe.sv
// Two-stage pipelined Hamming/SECDED encoder with valid/ready on both sides.
// Ports: clk_i/rst_i, in_valid_i/in_ready_o/data_i/inject_i/inject_pos_i,
//        out_valid_o/out_ready_i/code_o, sent_cnt_o (saturating delivery count).
module hamming_encode_pipe #(
  parameter  int DATA_WIDTH = 32,
  parameter  int SECDED     = 1,
  parameter  int INJECT_EN  = 1,
  parameter  int CNT_WIDTH  = 16,
  // smallest r with 2^r >= DATA_WIDTH + r + 1
  localparam int ADDR_WIDTH =
    $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1)),
  localparam int CODE_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1,
  localparam int POS_WIDTH  = $clog2(CODE_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  inject_i,
  input  logic [POS_WIDTH-1:0]  inject_pos_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CODE_WIDTH-1:0] code_o,
  output logic [CNT_WIDTH-1:0]  sent_cnt_o
);

  logic                  s1_valid_q, s1_valid_d;
  logic [CODE_WIDTH-1:0] s1_word_q, s1_word_d;
  logic                  s1_inj_q, s1_inj_d;
  logic [POS_WIDTH-1:0]  s1_pos_q, s1_pos_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [CODE_WIDTH-1:0] s2_code_q, s2_code_d;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  s1_adv, s2_adv;
  logic                  deliver;
  logic [CODE_WIDTH-1:0] packed_w;
  logic [CODE_WIDTH-1:0] enc_w;

  assign s2_adv  = !s2_valid_q || out_ready_i;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign deliver = s2_valid_q && out_ready_i;

  // Data bits fill the non-power-of-two positions in ascending order.
  always_comb begin
    int k;
    packed_w = '0;
    k        = 0;
    for (int p = 1; p < CODE_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        packed_w[p] = data_i[k];
        k           = k + 1;
      end
    end
  end

  // Parity positions are zero in the captured word, so each parity bit
  // can be taken over the full covered set without excluding itself.
  always_comb begin
    logic par;
    enc_w = s1_word_q;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      par = 1'b0;
      for (int p = 1; p < CODE_WIDTH; p++) begin
        if (((p >> i) & 1) != 0) par = par ^ s1_word_q[p];
      end
      enc_w[1 << i] = par;
    end
    if (SECDED != 0) enc_w[0] = ^enc_w[CODE_WIDTH-1:1];
    if ((INJECT_EN != 0) && s1_inj_q &&
        (int'(s1_pos_q) < CODE_WIDTH)) begin
      enc_w[s1_pos_q] = ~enc_w[s1_pos_q];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    s1_inj_d   = s1_inj_q;
    s1_pos_d   = s1_pos_q;
    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_word_d = packed_w;
        s1_inj_d  = inject_i;
        s1_pos_d  = inject_pos_i;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_code_d = enc_w;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_inj_q   <= 1'b0;
      s1_pos_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      s1_inj_q   <= s1_inj_d;
      s1_pos_q   <= s1_pos_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid_q;
  assign code_o      = s2_code_q;
  assign sent_cnt_o  = cnt_q;

endmodule
